vec_vrf_rd_arb: RTL
===================

Name: vec_vrf_rd_arb

Overview:
- Read-port arbiter/scheduler in front of the vector register file (32 entries x XLEN bits, RPORT registered read ports, 1-cycle read latency).
- Shares RPORT read ports among NREQ requesters (functional-unit operand fetch) with round-robin fairness.
- Merges same-register requests onto one port and routes returned data back to each granted requester.

Parameters:
- NREQ, 6, number of requesters (2..16)
- RPORT, 4, number of VRF read ports (1..NREQ)
- XLEN, 512, vector register width in bits

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  drop all in-flight responses; no new grants this cycle
- req_valid  input  NREQ  per-requester read request
- req_addr  input  NREQ x 5  per-requester VRF register index
- req_ready  output  NREQ  request accepted this cycle (combinational)
- rsp_valid  output  NREQ  read data valid for requester
- rsp_data  output  NREQ x XLEN  read data for requester
- vrf_rd_en  output  RPORT  to VRF read enable
- vrf_rd_addr  output  RPORT x 5  to VRF read address
- vrf_rd_data  input  RPORT x XLEN  from VRF; registered; valid the cycle after vrf_rd_en

Behaviour:
- Handshake: transfer when req_valid[i] & req_ready[i]. Requester holds valid and addr stable until ready. No response backpressure.
- Scan order each cycle: requesters rr_ptr, rr_ptr+1, ..., mod NREQ.
- For each valid requester in scan order:
  - if req_addr equals the address of a port already allocated this cycle, it joins that port (merge; consumes no port);
  - else if a free port exists, allocate the lowest-numbered free port;
  - else not granted.
- Granted requesters get req_ready=1. Allocated ports drive vrf_rd_en=1 and vrf_rd_addr; unallocated ports drive vrf_rd_en=0 and vrf_rd_addr=0.
- flush=1 or reset active: req_ready=0 and vrf_rd_en=0 for all.
- Tag register per port: tag_mask[k] (NREQ bits) <= mask of requesters granted on port k. Cleared when no grant on the port, on flush, and on reset.
- Response in cycle N+1 for an accept in cycle N:
  - rsp_valid[i] = OR over k of tag_mask[k][i], gated off while flush=1;
  - rsp_data[i] = vrf_rd_data[k] for the k with tag_mask[k][i]=1, else 0;
  - one-hot across k is guaranteed by construction.
- Pointer update (registered, only when flush=0):
  - if some valid requester was not granted, rr_ptr <= first such requester in scan order;
  - else if any grant, rr_ptr <= (rr_ptr+1) mod NREQ;
  - else unchanged.
- Fairness: a continuously valid requester is granted within ceil(NREQ/RPORT) cycles.
- Wrap-around: scan and pointer wrap NREQ-1 -> 0; NREQ need not be a power of two.
- Simultaneous flush and a response due: the response is suppressed (rsp_valid=0) and tags are cleared.
- Reset values: rr_ptr=0, all tag_mask=0, rsp_valid=0, rsp_data=0, vrf_rd_en=0, vrf_rd_addr=0, req_ready=0.
- Reset asserted mid-operation: in-flight responses are lost; after deassertion, operation is identical to power-up.
- Write-after-read forwarding is handled inside the VRF; the arbiter is address-agnostic apart from merging.

Optional Feature:
- Macro VEC_VRF_RD_ARB_PERF_EN adds two outputs, both 32-bit, saturating at 0xFFFFFFFF, reset to 0, not cleared by flush:
  - perf_grant_cnt: increments by the number of ports allocated per cycle.
  - perf_conflict_cnt: increments by 1 in each cycle where at least one valid requester is not granted.
- Without the macro: the ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Single request: NREQ=6, RPORT=4; req 2 addr 5 at cycle 0 -> req_ready[2]=1, vrf_rd_en[0]=1, vrf_rd_addr[0]=5; cycle 1 rsp_valid[2]=1, rsp_data[2]=vrf_rd_data[0], other rsp_valid=0.
- Oversubscription: all 6 valid with distinct addrs 0..5, rr_ptr=0 -> cycle 0 grants 0..3 on ports 0..3, rr_ptr<=4; cycle 1 grants 4,5 on ports 0,1, then 0,1 on ports 2,3.
- Merge: req 0,1,3 all addr 7, req 4 addr 9 -> only ports 0 (addr 7) and 1 (addr 9) enabled; next cycle rsp_valid=6'b011011, rsp_data[0]=rsp_data[1]=rsp_data[3]=vrf_rd_data[0].
- Flush: grant at cycle 0, flush=1 at cycle 1 -> rsp_valid=0 at cycle 1, no vrf_rd_en at cycle 1, rr_ptr unchanged at cycle 1.
- Reset mid-flight: grants at cycle 0, rst_n low at cycle 1 -> all outputs 0 immediately; after release, the first grant starts from requester 0.
- PERF (macro on): 6 distinct requests held for 2 cycles -> perf_grant_cnt=8, perf_conflict_cnt=2; force near 0xFFFFFFFF -> holds at max.

Source files
------------

// File: rtl/vec_vrf_rd_arb.sv
// rtl/vec_vrf_rd_arb.sv - round-robin VRF read-port arbiter with same-register merging
// Optional perf counters: define VEC_VRF_RD_ARB_PERF_EN.
module vec_vrf_rd_arb #(
    parameter int NREQ  = 6,
    parameter int RPORT = 4,
    parameter int XLEN  = 512
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0][4:0]         req_addr,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [NREQ-1:0][XLEN-1:0]    rsp_data,
    output logic [RPORT-1:0]             vrf_rd_en,
    output logic [RPORT-1:0][4:0]        vrf_rd_addr,
    input  logic [RPORT-1:0][XLEN-1:0]   vrf_rd_data
`ifdef VEC_VRF_RD_ARB_PERF_EN
    ,
    output logic [31:0]                  perf_grant_cnt,
    output logic [31:0]                  perf_conflict_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]                 rr_ptr;
    logic [PW-1:0]                 ptr_next;
    logic [PW-1:0]                 scan_idx;
    logic                          arb_en;
    logic                          merged;
    logic                          placed;
    logic                          miss_found;
    logic [NREQ-1:0]               grant;
    logic [RPORT-1:0]              port_used;
    logic [RPORT-1:0][4:0]         port_addr;
    logic [RPORT-1:0][NREQ-1:0]    tag_next;
    logic [RPORT-1:0][NREQ-1:0]    tag_mask;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    assign arb_en = rst_n & ~flush;

    // Scan from rr_ptr; a requester first tries to merge onto an already
    // allocated port with the same address, then takes the lowest free port.
    always_comb begin
        grant      = '0;
        port_used  = '0;
        port_addr  = '0;
        tag_next   = '0;
        miss_found = 1'b0;
        ptr_next   = rr_ptr;
        scan_idx   = rr_ptr;
        merged     = 1'b0;
        placed     = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            scan_idx = wrap_add(rr_ptr, j);
            merged   = 1'b0;
            placed   = 1'b0;
            if (arb_en && req_valid[scan_idx]) begin
                for (int k = 0; k < RPORT; k++) begin
                    if (!merged && port_used[k] && port_addr[k] == req_addr[scan_idx]) begin
                        merged                = 1'b1;
                        grant[scan_idx]       = 1'b1;
                        tag_next[k][scan_idx] = 1'b1;
                    end
                end
                if (!merged) begin
                    for (int k = 0; k < RPORT; k++) begin
                        if (!placed && !port_used[k]) begin
                            placed                = 1'b1;
                            port_used[k]          = 1'b1;
                            port_addr[k]          = req_addr[scan_idx];
                            grant[scan_idx]       = 1'b1;
                            tag_next[k][scan_idx] = 1'b1;
                        end
                    end
                    if (!placed && !miss_found) begin
                        miss_found = 1'b1;
                        ptr_next   = scan_idx;
                    end
                end
            end
        end
        if (!miss_found && (|grant)) ptr_next = wrap_add(rr_ptr, 1);
    end

    assign req_ready   = grant;
    assign vrf_rd_en   = port_used;
    assign vrf_rd_addr = port_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            tag_mask <= '0;
        end else if (flush) begin
            tag_mask <= '0;
        end else begin
            tag_mask <= tag_next;
            rr_ptr   <= ptr_next;
        end
    end

    // Tags are one-hot across ports per requester, so the OR-mux is a plain select.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < RPORT; k++) begin
                if (tag_mask[k][i]) begin
                    rsp_valid[i] = ~flush;
                    rsp_data[i]  = vrf_rd_data[k];
                end
            end
        end
    end

`ifdef VEC_VRF_RD_ARB_PERF_EN
    logic [32:0] alloc_cnt;
    logic [32:0] grant_sum;
    logic        conflict;

    always_comb begin
        alloc_cnt = '0;
        for (int k = 0; k < RPORT; k++) alloc_cnt = alloc_cnt + 33'(port_used[k]);
    end

    assign grant_sum = {1'b0, perf_grant_cnt} + alloc_cnt;
    assign conflict  = |(req_valid & ~grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            perf_grant_cnt <= grant_sum[32] ? 32'hFFFF_FFFF : grant_sum[31:0];
            if (conflict && perf_conflict_cnt != 32'hFFFF_FFFF)
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
